// File: rtl/rvfi_commit_tracker.sv
// Turns writeback-stage retirements into registered RVFI commit pulses, keeps the
// retirement order count, detects the branch-to-self halt idiom and a commit watchdog.
module rvfi_commit_tracker #(
    parameter int unsigned HALT_REPEAT = 2,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        wb_stall,
    input  logic        flush,
    input  logic [31:0] wb_inst,
    input  logic [31:0] wb_pc_rdata,
    input  logic [31:0] wb_pc_wdata,
    input  logic        wb_load_regfile,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_wdata,
    input  logic [31:0] wb_mem_addr,
    input  logic [3:0]  wb_mem_rmask,
    input  logic [3:0]  wb_mem_wmask,
    output logic        commit,
    output logic        halt,
    output logic [63:0] order,
    output logic [31:0] rvfi_inst,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask,
    output logic        timeout
);

    // state  | meaning
    // RUN    | normal retirement, no pending self-loop
    // PEND   | at least one self-loop retired, halt threshold not yet met
    // HALTED | halt idiom seen; retirement suppressed until reset
    typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

    localparam logic [4:0]  HALT_N = 5'(HALT_REPEAT);
    localparam logic [15:0] TO_N   = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic        ret, self_loop, halt_hit, rd_keep;
    logic [63:0] cnt;
    logic [3:0]  rep;
    logic [15:0] wd, wd_nxt;

    assign self_loop = (wb_pc_wdata == wb_pc_rdata);
    assign ret       = wb_valid & ~wb_stall & ~flush & (state != HALTED);
    assign halt_hit  = ret & self_loop & (({1'b0, rep} + 5'd1) == HALT_N);
    assign rd_keep   = wb_load_regfile & (wb_rd_addr != 5'd0);
    assign halt      = (state == HALTED);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (halt_hit)              state_nxt = HALTED;
                else if (ret && self_loop) state_nxt = PEND;
            end
            PEND: begin
                if (halt_hit)               state_nxt = HALTED;
                else if (ret && !self_loop) state_nxt = RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Watchdog stops counting once halted so a clean halt never reads as starvation
    always_comb begin
        wd_nxt = wd;
        if (ret)                                wd_nxt = 16'd0;
        else if (state != HALTED && wd != TO_N) wd_nxt = wd + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            commit         <= 1'b0;
            order          <= 64'd0;
            cnt            <= 64'd0;
            rep            <= 4'd0;
            wd             <= 16'd0;
            timeout        <= 1'b0;
            rvfi_inst      <= 32'd0;
            rvfi_pc_rdata  <= 32'd0;
            rvfi_pc_wdata  <= 32'd0;
            rvfi_rd_addr   <= 5'd0;
            rvfi_rd_wdata  <= 32'd0;
            rvfi_mem_addr  <= 32'd0;
            rvfi_mem_rmask <= 4'd0;
            rvfi_mem_wmask <= 4'd0;
        end else begin
            state   <= state_nxt;
            commit  <= ret;
            wd      <= wd_nxt;
            timeout <= timeout | (wd_nxt == TO_N);
            if (ret) begin
                order          <= cnt;
                cnt            <= cnt + 64'd1;
                rep            <= self_loop ? ((rep == 4'd15) ? rep : rep + 4'd1) : 4'd0;
                rvfi_inst      <= wb_inst;
                rvfi_pc_rdata  <= wb_pc_rdata;
                rvfi_pc_wdata  <= wb_pc_wdata;
                rvfi_rd_addr   <= rd_keep ? wb_rd_addr : 5'd0;
                rvfi_rd_wdata  <= rd_keep ? wb_rd_wdata : 32'd0;
                rvfi_mem_addr  <= wb_mem_addr;
                rvfi_mem_rmask <= wb_mem_rmask;
                rvfi_mem_wmask <= wb_mem_wmask;
            end
        end
    end

endmodule

// File: doc/rvfi_commit_tracker.md
Name: rvfi_commit_tracker

Overview:
- Sits between the writeback stage of mp3 and the testbench RVFI monitor.
- Qualifies writeback-stage retirements into single-cycle commit pulses and registers the RVFI fields.
- Maintains the 64-bit retirement order counter and detects the branch-to-self halt idiom.
- Flags a commit-starvation watchdog timeout; replaces the constant commit/halt/order ties in the bench top.

Parameters:
HALT_REPEAT, 2, consecutive self-loop commits required to declare halt (legal range 1..15)
TIMEOUT, 1000, cycles without a commit before timeout asserts (legal range 2..65535)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous assert, active-low (0 = in reset)
wb_valid  input  1  writeback stage holds a real instruction
wb_stall  input  1  writeback stage is held this cycle
flush  input  1  writeback instruction is squashed this cycle
wb_inst  input  32  instruction word
wb_pc_rdata  input  32  PC of the instruction
wb_pc_wdata  input  32  next PC produced by the instruction
wb_load_regfile  input  1  instruction writes the register file
wb_rd_addr  input  5  destination register
wb_rd_wdata  input  32  destination write data
wb_mem_addr  input  32  data memory address
wb_mem_rmask  input  4  data read byte mask
wb_mem_wmask  input  4  data write byte mask
commit  output  1  one instruction retired (registered)
halt  output  1  sticky halt detected
order  output  64  order number of the committed instruction
rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata  output  32 each  registered copies
rvfi_rd_addr  output  5  registered, masked as below
rvfi_rd_wdata  output  32  registered, masked as below
rvfi_mem_addr  output  32  registered
rvfi_mem_rmask, rvfi_mem_wmask  output  4 each  registered
timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, internal order count 0, repeat counter 0, watchdog 0, FSM in RUN.
- Retire condition: ret = wb_valid & ~wb_stall & ~flush & (state != HALTED).
- Latency 1: on the clk edge where ret=1, commit<=1 and every rvfi_* field loads from the wb_* inputs. commit<=0 on any edge where ret=0; rvfi_* hold their last values.
- Masking: if wb_load_regfile=0 or wb_rd_addr=0, load rvfi_rd_addr=0 and rvfi_rd_wdata=0.
- Order: internal count cnt starts at 0. On ret, order<=cnt and cnt<=cnt+1, so the first commit reports order 0. The count wraps modulo 2^64 with no flag.
- Self-loop counter rep (4 bits):
  - On ret with wb_pc_wdata==wb_pc_rdata: rep<=rep+1, saturating at 15.
  - On ret with any other PC pair: rep<=0.
  - When ret=0: rep holds.
- FSM states RUN, PEND, HALTED:
  - RUN->PEND on a self-loop ret while HALTED is not yet reached.
  - PEND->RUN on a non-self-loop ret.
  - RUN/PEND->HALTED on the self-loop ret that brings rep+1 to HALT_REPEAT. That same instruction still commits, and halt<=1 on that edge, coincident with its commit.
  - HALTED is terminal until reset. In HALTED, commit stays 0 and halt stays 1.
- Watchdog wd (16 bits):
  - Cleared on ret; otherwise incremented, saturating at TIMEOUT.
  - timeout<=1 on the edge where wd reaches TIMEOUT; sticky until reset.
  - Frozen (no increment) in HALTED.
- Simultaneous events:
  - flush with wb_valid: no commit.
  - wb_stall with wb_valid: no commit, and the held instruction commits exactly once, on release.
- Reset mid-operation: outputs clear asynchronously in the same cycle. The first retirement after rst=1 reports order 0.

Test Plan:
- Reset then three back-to-back rets at PCs 0x60,0x64,0x68 -> commit high for 3 cycles, one cycle after each; order=0,1,2; rvfi_pc_wdata=0x64,0x68,0x6C.
- ret with wb_rd_addr=0, wb_rd_wdata=0xDEADBEEF, wb_load_regfile=1 -> rvfi_rd_addr=0, rvfi_rd_wdata=0. Separately, wb_load_regfile=0 with rd=5 -> both 0.
- wb_valid=1 with wb_stall=1 for 4 cycles then stall released -> exactly one commit pulse, on the cycle after release. wb_valid=1 with flush=1 -> no commit, order unchanged.
- HALT_REPEAT=2, rets at pc=0x80 with pc_wdata=0x80, first two ->
  - first commit: halt=0;
  - second commit: halt=1 in the same cycle;
  - a third wb_valid: no commit, halt remains 1.
- Self-loop ret, then a ret at pc 0x84 -> FSM returns to RUN, rep=0, halt stays 0.
- TIMEOUT=10, no rets after reset -> timeout=1 on the 10th clk edge and remains 1 after a later commit. Pulse rst=0 mid-run -> all outputs 0 immediately.
